// File: rtl/ahb_irq_ctrl.sv
// AHB-Lite interrupt controller: synchronise, qualify, latch, mask and prioritise NSRC sources.
// Latency: src_in rise to PENDING in SYNC_STAGES+1 edges; PENDING/ENABLE to irq_vec/irq_o combinational.
// Backpressure: none, the slave is zero-wait (hready=1, hresp=OKAY); unmapped offsets read 0 and drop writes.
//
// Ports:
//   hclk, hresetn            clock, asynchronous active-low reset
//   hsel..hready_in          AHB-Lite slave request (hburst ignored, every beat is a single)
//   hready, hrdata, hresp    AHB-Lite slave response
//   src_in                   raw asynchronous interrupt sources, active-high
//   irq_vec, irq_o           masked pending vector and its OR, to the core's irq inputs
//
// Register map (byte offset, decoded on haddr[4:2]):
//   0x00 PENDING R/W1C, 0x04 ENABLE RW, 0x08 MODE RW (1=edge, 0=level),
//   0x0C ACTIVE RO (pending & enable), 0x10 ID RO (1 + lowest active index, 0 if none)
module ahb_irq_ctrl #(
   parameter int NSRC        = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic            hclk,
   input  logic            hresetn,
   input  logic            hsel,
   input  logic [31:0]     haddr,
   input  logic [1:0]      htrans,
   input  logic            hwrite,
   input  logic [2:0]      hsize,
   input  logic [2:0]      hburst,
   input  logic [31:0]     hwdata,
   input  logic            hready_in,
   output logic            hready,
   output logic [31:0]     hrdata,
   output logic [1:0]      hresp,
   input  logic [NSRC-1:0] src_in,
   output logic [NSRC-1:0] irq_vec,
   output logic            irq_o
);

   localparam logic [2:0] OFF_PENDING = 3'd0;
   localparam logic [2:0] OFF_ENABLE  = 3'd1;
   localparam logic [2:0] OFF_MODE    = 3'd2;
   localparam logic [2:0] OFF_ACTIVE  = 3'd3;
   localparam logic [2:0] OFF_ID      = 3'd4;

   // Source path
   logic [SYNC_STAGES-1:0][NSRC-1:0] sync_q;
   logic [NSRC-1:0] src_sync;
   logic [NSRC-1:0] src_dly;
   logic [NSRC-1:0] src_rise;

   // Register file
   logic [NSRC-1:0] pending_q;
   logic [NSRC-1:0] pending_d;
   logic [NSRC-1:0] enable_q;
   logic [NSRC-1:0] mode_q;
   logic [NSRC-1:0] active;
   logic [NSRC-1:0] w1c;
   logic [4:0]      irq_id;

   // Bus pipeline
   logic        addr_vld;
   logic        dp_vld_q;
   logic        dp_write_q;
   logic        dp_word_q;
   logic [2:0]  dp_addr_q;
   logic        wr_en;
   logic [31:0] rd_word;

   // Bus fields that carry no information for this slave.
   logic unused_ok;
   assign unused_ok = ^{hburst, haddr[31:5], haddr[1:0], htrans[0], hwdata[31:NSRC]};

   assign hready = 1'b1;
   assign hresp  = 2'b00;

   // ------------------------------------------------------------------
   // Synchroniser chain plus one delay flop for rising-edge detection.
   // ------------------------------------------------------------------
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         sync_q  <= '0;
         src_dly <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], src_in};
         src_dly <= src_sync;
      end
   end

   assign src_sync = sync_q[SYNC_STAGES-1];
   assign src_rise = src_sync & ~src_dly;

   // ------------------------------------------------------------------
   // Address phase latch. NONSEQ and SEQ both qualify; BUSY/IDLE do not.
   // ------------------------------------------------------------------
   assign addr_vld = hsel & hready_in & htrans[1];

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         dp_vld_q   <= 1'b0;
         dp_write_q <= 1'b0;
         dp_word_q  <= 1'b0;
         dp_addr_q  <= 3'd0;
      end else begin
         dp_vld_q <= addr_vld;
         if (addr_vld) begin
            dp_write_q <= hwrite;
            dp_addr_q  <= haddr[4:2];
            dp_word_q  <= (hsize == 3'b010);
         end
      end
   end

   // Writes commit at the end of the data phase; sub-word writes are dropped.
   assign wr_en = dp_vld_q & dp_write_q & dp_word_q;
   assign w1c   = (wr_en && dp_addr_q == OFF_PENDING) ? hwdata[NSRC-1:0] : '0;

   // Edge bits: a new rise wins over a same-cycle W1C of that bit.
   // Level bits: track the synchronised input, so W1C has no lasting effect
   // and a switch from edge to level overwrites pending one edge later.
   assign pending_d = (mode_q & (src_rise | (pending_q & ~w1c)))
                    | (~mode_q & src_sync);

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         pending_q <= '0;
         enable_q  <= '0;
         mode_q    <= '0;
      end else begin
         pending_q <= pending_d;
         if (wr_en && dp_addr_q == OFF_ENABLE) begin
            enable_q <= hwdata[NSRC-1:0];
         end
         if (wr_en && dp_addr_q == OFF_MODE) begin
            mode_q <= hwdata[NSRC-1:0];
         end
      end
   end

   // ------------------------------------------------------------------
   // Masking and priority: lowest-numbered active source wins.
   // ------------------------------------------------------------------
   assign active  = pending_q & enable_q;
   assign irq_vec = active;
   assign irq_o   = |active;

   always_comb begin
      irq_id = 5'd0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (active[i]) begin
            irq_id = 5'(i + 1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Read data. Built from flops only, so a read whose address phase
   // overlaps a write's data phase already sees the written value.
   // ------------------------------------------------------------------
   always_comb begin
      rd_word = '0;
      case (dp_addr_q)
         OFF_PENDING: rd_word[NSRC-1:0] = pending_q;
         OFF_ENABLE:  rd_word[NSRC-1:0] = enable_q;
         OFF_MODE:    rd_word[NSRC-1:0] = mode_q;
         OFF_ACTIVE:  rd_word[NSRC-1:0] = active;
         OFF_ID:      rd_word[4:0]      = irq_id;
         default:     rd_word           = '0;
      endcase
   end

   assign hrdata = (dp_vld_q && !dp_write_q) ? rd_word : 32'd0;

endmodule

// File: tb/tb_ahb_irq_ctrl.sv
// Bench for ahb_irq_ctrl: directed scenarios plus randomized bus/source traffic.
// Every cycle the DUT outputs are compared with a behavioural model of the register rules.
// All checks go through chk(); one summary line at the end.
module tb_ahb_irq_ctrl;

   localparam int N = 8;
   localparam int S = 2;

   localparam logic [31:0] A_PEND = 32'h00;
   localparam logic [31:0] A_EN   = 32'h04;
   localparam logic [31:0] A_MODE = 32'h08;
   localparam logic [31:0] A_ACT  = 32'h0C;
   localparam logic [31:0] A_ID   = 32'h10;

   logic          hclk;
   logic          hresetn;
   logic          hsel;
   logic [31:0]   haddr;
   logic [1:0]    htrans;
   logic          hwrite;
   logic [2:0]    hsize;
   logic [2:0]    hburst;
   logic [31:0]   hwdata;
   logic          hready_in;
   logic          hready;
   logic [31:0]   hrdata;
   logic [1:0]    hresp;
   logic [N-1:0]  src_in;
   logic [N-1:0]  irq_vec;
   logic          irq_o;

   int n_checks = 0;
   int n_errors = 0;

   ahb_irq_ctrl #(.NSRC(N), .SYNC_STAGES(S)) dut (
      .hclk      (hclk),
      .hresetn   (hresetn),
      .hsel      (hsel),
      .haddr     (haddr),
      .htrans    (htrans),
      .hwrite    (hwrite),
      .hsize     (hsize),
      .hburst    (hburst),
      .hwdata    (hwdata),
      .hready_in (hready_in),
      .hready    (hready),
      .hrdata    (hrdata),
      .hresp     (hresp),
      .src_in    (src_in),
      .irq_vec   (irq_vec),
      .irq_o     (irq_o)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   // ---------------- reference model ----------------
   logic [N-1:0] m_pend, m_en, m_mode, m_prev;
   logic [N-1:0] m_hist [S];    // m_hist[k] = src_in as sampled k+1 edges ago
   logic         m_dp_vld, m_dp_wr, m_dp_word;
   logic [2:0]   m_dp_off;

   task automatic m_clear();
      m_pend = '0; m_en = '0; m_mode = '0; m_prev = '0;
      for (int k = 0; k < S; k++) m_hist[k] = '0;
      m_dp_vld = 1'b0; m_dp_wr = 1'b0; m_dp_word = 1'b0; m_dp_off = 3'd0;
   endtask

   function automatic logic [31:0] m_reg(input logic [2:0] off);
      logic [N-1:0] act;
      int id;
      act = m_pend & m_en;
      id = 0;
      for (int i = 0; i < N; i++) begin
         if (id == 0 && act[i]) id = i + 1;
      end
      case (off)
         3'd0:    return 32'(m_pend);
         3'd1:    return 32'(m_en);
         3'd2:    return 32'(m_mode);
         3'd3:    return 32'(act);
         3'd4:    return 32'(id);
         default: return 32'd0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One clock: predict the edge from the pre-edge inputs, then compare at the falling edge.
   task automatic tick();
      logic [N-1:0] sync, np, ne, nm;
      logic [N-1:0] s_src;
      logic [31:0]  s_wd;
      logic         do_wr, n_vld, n_wr, n_word;
      logic [2:0]   n_off;
      logic [31:0]  exp_rd;
      sync  = m_hist[S-1];
      s_src = src_in;
      s_wd  = hwdata;
      do_wr = m_dp_vld && m_dp_wr && m_dp_word;
      np = m_pend; ne = m_en; nm = m_mode;
      for (int b = 0; b < N; b++) begin
         if (m_mode[b]) begin
            if (sync[b] && !m_prev[b])                          np[b] = 1'b1;
            else if (do_wr && m_dp_off == 3'd0 && s_wd[b])      np[b] = 1'b0;
         end else begin
            np[b] = sync[b];
         end
      end
      if (do_wr && m_dp_off == 3'd1) ne = s_wd[N-1:0];
      if (do_wr && m_dp_off == 3'd2) nm = s_wd[N-1:0];
      n_vld  = hsel && hready_in && htrans[1];
      n_wr   = n_vld ? hwrite : m_dp_wr;
      n_off  = n_vld ? haddr[4:2] : m_dp_off;
      n_word = n_vld ? (hsize == 3'b010) : m_dp_word;
      @(posedge hclk);
      @(negedge hclk);
      if (!hresetn) begin
         m_clear();
      end else begin
         m_pend = np; m_en = ne; m_mode = nm;
         m_prev = sync;
         for (int k = S - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
         m_hist[0] = s_src;
         m_dp_vld = n_vld; m_dp_wr = n_wr; m_dp_off = n_off; m_dp_word = n_word;
      end
      exp_rd = (m_dp_vld && !m_dp_wr) ? m_reg(m_dp_off) : 32'd0;
      chk("irq_vec", 32'(irq_vec), 32'(m_pend & m_en));
      chk("irq_o",   32'(irq_o),   32'(|(m_pend & m_en)));
      chk("hrdata",  hrdata,       exp_rd);
      chk("hready",  32'(hready),  32'd1);
      chk("hresp",   32'(hresp),   32'd0);
   endtask

   // ---------------- bus helpers ----------------
   task automatic bus_idle();
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 32'd0;
      hsize = 3'b010; hburst = 3'b000; hready_in = 1'b1;
   endtask

   task automatic addr_ph(input logic wr, input logic [31:0] a, input logic [2:0] sz);
      hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz; hready_in = 1'b1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
      addr_ph(1'b1, a, sz);
      tick();
      bus_idle();
      hwdata = d;
      tick();
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      addr_ph(1'b0, a, 3'b010);
      tick();
      d = hrdata;
      bus_idle();
      tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] rv;
      m_clear();
      bus_idle();
      hwdata  = 32'd0;
      src_in  = '1;
      hresetn = 1'b1;
      #2 hresetn = 1'b0;

      // Reset: sources all high, outputs must stay quiet.
      repeat (3) tick();
      chk("rst_irq_vec", 32'(irq_vec), 32'd0);
      chk("rst_irq_o",   32'(irq_o),   32'd0);
      chk("rst_hrdata",  hrdata,       32'd0);
      chk("rst_hready",  32'(hready),  32'd1);
      chk("rst_hresp",   32'(hresp),   32'd0);
      src_in  = '0;
      hresetn = 1'b1;
      rd(A_PEND, rv); chk("rst_pending", rv, 32'd0);
      rd(A_EN,   rv); chk("rst_enable",  rv, 32'd0);
      rd(A_MODE, rv); chk("rst_mode",    rv, 32'd0);
      rd(A_ACT,  rv); chk("rst_active",  rv, 32'd0);
      rd(A_ID,   rv); chk("rst_id",      rv, 32'd0);

      // Edge capture: 2-cycle pulse on source 2, pending exactly 3 edges after the rise.
      wr(A_MODE, 32'hFF, 3'b010);
      wr(A_EN,   32'h05, 3'b010);
      src_in = 8'h04;
      tick(); chk("edge_e1", 32'(irq_vec), 32'h00);
      tick(); chk("edge_e2", 32'(irq_vec), 32'h00);
      src_in = 8'h00;
      tick(); chk("edge_e3", 32'(irq_vec), 32'h04);
      rd(A_PEND, rv); chk("edge_pending", rv, 32'h04);
      rd(A_ACT,  rv); chk("edge_active",  rv, 32'h04);
      rd(A_ID,   rv); chk("edge_id",      rv, 32'd3);
      chk("edge_irq_o", 32'(irq_o), 32'd1);
      wr(A_PEND, 32'h04, 3'b010);
      chk("edge_w1c_irq_o", 32'(irq_o), 32'd0);

      // Set beats clear: W1C of bit 0 commits on the same edge the rise sets it.
      src_in = 8'h01;
      tick();
      addr_ph(1'b1, A_PEND, 3'b010);
      tick();
      bus_idle();
      hwdata = 32'h01;
      tick();
      chk("setclr_vec", 32'(irq_vec), 32'h01);
      src_in = 8'h00;
      rd(A_PEND, rv); chk("setclr_pending", rv, 32'h01);
      wr(A_PEND, 32'h01, 3'b010);

      // Level mode: pending follows the input, W1C has no effect.
      wr(A_MODE, 32'h00, 3'b010);
      wr(A_EN,   32'h02, 3'b010);
      src_in = 8'h02;
      repeat (4) tick();
      rd(A_PEND, rv); chk("lvl_pending", rv, 32'h02);
      wr(A_PEND, 32'h02, 3'b010);
      rd(A_PEND, rv); chk("lvl_w1c_ignored", rv, 32'h02);
      src_in = 8'h00;
      tick(); chk("lvl_hold", 32'(irq_vec), 32'h02);
      tick();
      tick(); chk("lvl_drop", 32'(irq_vec), 32'h00);

      // Bus protocol: back-to-back write then read of ENABLE.
      addr_ph(1'b1, A_EN, 3'b010);
      tick();
      addr_ph(1'b0, A_EN, 3'b010);
      hwdata = 32'hA5;
      tick();
      chk("b2b_raw", hrdata, 32'hA5);
      bus_idle();
      tick();
      wr(A_EN, 32'hFF, 3'b000);
      rd(A_EN, rv); chk("byte_wr_ignored", rv, 32'hA5);
      hsel = 1'b1; htrans = 2'b00; hwrite = 1'b1; haddr = A_EN; hsize = 3'b010;
      tick();
      bus_idle(); hwdata = 32'h00;
      tick();
      rd(A_EN, rv); chk("idle_wr_ignored", rv, 32'hA5);
      addr_ph(1'b1, A_EN, 3'b010);
      hready_in = 1'b0;
      tick();
      bus_idle(); hwdata = 32'h00;
      tick();
      rd(A_EN, rv); chk("nordy_wr_ignored", rv, 32'hA5);
      rd(32'h1C, rv); chk("unmapped_1c", rv, 32'd0);
      wr(32'h14, 32'hFFFF_FFFF, 3'b010);
      rd(32'h14, rv); chk("unmapped_14", rv, 32'd0);

      // Priority and masking.
      wr(A_MODE, 32'hFF, 3'b010);
      wr(A_PEND, 32'hFF, 3'b010);
      wr(A_EN,   32'h20, 3'b010);
      src_in = 8'h30;
      repeat (2) tick();
      src_in = 8'h00;
      repeat (3) tick();
      rd(A_PEND, rv); chk("prio_pending", rv, 32'h30);
      rd(A_ID,   rv); chk("prio_id_masked", rv, 32'd6);
      chk("prio_vec_masked", 32'(irq_vec), 32'h20);
      wr(A_EN, 32'h30, 3'b010);
      rd(A_ID, rv); chk("prio_id_both", rv, 32'd5);
      chk("prio_vec_both", 32'(irq_vec), 32'h30);

      // Randomized traffic, with one asynchronous reset in the middle.
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) hresetn = 1'b0;
         if (c == 1503) hresetn = 1'b1;
         hsel      = ($urandom_range(3) != 0);
         htrans    = 2'($urandom_range(3));
         hwrite    = 1'($urandom_range(1));
         haddr     = $urandom;
         hsize     = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'b010;
         hburst    = 3'($urandom_range(7));
         hready_in = ($urandom_range(7) != 0);
         hwdata    = $urandom;
         if ($urandom_range(3) == 0) src_in = N'($urandom);
         tick();
      end
      bus_idle();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
